// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - producer and register-file write-port bundle for wb_arbiter
// slave is the arbiter side, master is the producer/register-file side.
interface wb_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 32
);
  logic            alu_valid;
  logic [AW-1:0]   alu_reg;
  logic [DW-1:0]   alu_data;
  logic            alu_stall;
  logic            lu_valid;
  logic [AW-1:0]   lu_reg;
  logic [DW-1:0]   lu_data;
  logic            lu_ready;
  logic            write_en;
  logic [AW-1:0]   write_reg;
  logic [DW-1:0]   write_data;
  logic [2**AW-1:0] pend_mask;

  modport slave (
    input  alu_valid, alu_reg, alu_data, lu_valid, lu_reg, lu_data,
    output alu_stall, lu_ready, write_en, write_reg, write_data, pend_mask
  );

  modport master (
    output alu_valid, alu_reg, alu_data, lu_valid, lu_reg, lu_data,
    input  alu_stall, lu_ready, write_en, write_reg, write_data, pend_mask
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: ALU priority, in-order long-unit queue with squash
// Define WB_BYPASS_EN to let a long-unit result skip an empty queue when the ALU is idle.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NR = 2**AW;

  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] live_nxt;
  logic [AW-1:0] ent_reg  [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic enq;
  logic pop;
  logic alu_take;
  logic bypass;
  logic head_live;
  logic          nxt_en;
  logic [AW-1:0] nxt_reg;
  logic [DW-1:0] nxt_data;
  logic [NR-1:0] pend;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.lu_valid && !full;
  assign alu_take  = bus.alu_valid && !full;
  // A full queue always drains, otherwise the ALU keeps the port.
  assign pop       = !empty && (full || !alu_take);
  assign head_live = live[rd_ptr];

`ifdef WB_BYPASS_EN
  assign bypass = empty && !bus.alu_valid && push;
`else
  assign bypass = 1'b0;
`endif

  assign enq           = push && !bypass;
  assign bus.alu_stall = full;
  assign bus.lu_ready  = !full;

  always_comb begin
    nxt_en   = 1'b0;
    nxt_reg  = bus.write_reg;
    nxt_data = bus.write_data;
    if (alu_take) begin
      nxt_en   = 1'b1;
      nxt_reg  = bus.alu_reg;
      nxt_data = bus.alu_data;
    end else if (pop) begin
      if (head_live) begin
        nxt_en   = 1'b1;
        nxt_reg  = ent_reg[rd_ptr];
        nxt_data = ent_data[rd_ptr];
      end
    end else if (bypass) begin
      nxt_en   = 1'b1;
      nxt_reg  = bus.lu_reg;
      nxt_data = bus.lu_data;
    end
  end

  // Queued results are always older than the ALU write, so a matching ALU write kills them.
  always_comb begin
    live_nxt = live;
    if (alu_take) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_reg[i] == bus.alu_reg) live_nxt[i] = 1'b0;
      end
    end
    if (pop) live_nxt[rd_ptr] = 1'b0;
    if (enq) live_nxt[wr_ptr] = !(alu_take && (bus.lu_reg == bus.alu_reg));
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pend[ent_reg[i]] = 1'b1;
    end
  end

  assign bus.pend_mask = pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      live           <= '0;
      bus.write_en   <= 1'b0;
      bus.write_reg  <= '0;
      bus.write_data <= '0;
    end else begin
      count          <= count + CW'(enq) - CW'(pop);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      live           <= live_nxt;
      bus.write_en   <= nxt_en;
      bus.write_reg  <= nxt_reg;
      bus.write_data <= nxt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_reg[wr_ptr]  <= bus.lu_reg;
      ent_data[wr_ptr] <= bus.lu_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and scoreboarded checks of wb_arbiter
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  wb_arbiter_if #(.AW(3), .DW(32)) bus ();

  wb_arbiter #(.DEPTH(4), .AW(3), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.lu_valid  = 1'b0;
  endtask

  logic [34:0] exp_q [$];
  logic [34:0] exp_head;
  int          pushed;
  int          cycles;
  bit          lu_acc;
  bit          alu_acc;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_reg   = '0;
    bus.alu_data  = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_reg    = '0;
    bus.lu_data   = '0;
    tick();
    tick();
    chk("rst_write_en",   64'(bus.write_en),   64'(0));
    chk("rst_write_reg",  64'(bus.write_reg),  64'(0));
    chk("rst_write_data", 64'(bus.write_data), 64'(0));
    chk("rst_pend_mask",  64'(bus.pend_mask),  64'(0));
    chk("rst_alu_stall",  64'(bus.alu_stall),  64'(0));
    chk("rst_lu_ready",   64'(bus.lu_ready),   64'(1));
    rst = 1'b0;
    tick();

    // single long-unit result
    bus.lu_valid = 1'b1;
    bus.lu_reg   = 3'd5;
    bus.lu_data  = 32'hDEADBEEF;
    tick();
    idle();
`ifdef WB_BYPASS_EN
    chk("t1_en_c1",   64'(bus.write_en),   64'(1));
    chk("t1_reg_c1",  64'(bus.write_reg),  64'(5));
    chk("t1_data_c1", 64'(bus.write_data), 64'h0000_0000_DEAD_BEEF);
    chk("t1_pend_c1", 64'(bus.pend_mask),  64'(0));
    tick();
    chk("t1_en_c2",   64'(bus.write_en),   64'(0));
`else
    chk("t1_en_c1",   64'(bus.write_en),   64'(0));
    chk("t1_pend_c1", 64'(bus.pend_mask),  64'h20);
    tick();
    chk("t1_en_c2",   64'(bus.write_en),   64'(1));
    chk("t1_reg_c2",  64'(bus.write_reg),  64'(5));
    chk("t1_data_c2", 64'(bus.write_data), 64'h0000_0000_DEAD_BEEF);
    chk("t1_pend_c2", 64'(bus.pend_mask),  64'(0));
`endif
    tick();
    chk("t1_idle_en", 64'(bus.write_en), 64'(0));

    // fill the queue behind a busy ALU
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_reg   = (i % 2 == 1) ? 3'd7 : 3'd6;
      bus.alu_data  = 32'hA0 + 32'(i);
      bus.lu_valid  = 1'b1;
      bus.lu_reg    = 3'(i + 1);
      bus.lu_data   = 32'hB0 + 32'(i);
      tick();
      chk("t2_alu_en",   64'(bus.write_en),   64'(1));
      chk("t2_alu_reg",  64'(bus.write_reg),  (i % 2 == 1) ? 64'(7) : 64'(6));
      chk("t2_alu_data", 64'(bus.write_data), 64'(32'hA0 + 32'(i)));
    end
    bus.lu_valid = 1'b0;
    chk("t2_lu_ready_full",  64'(bus.lu_ready),  64'(0));
    chk("t2_alu_stall_full", 64'(bus.alu_stall), 64'(1));
    chk("t2_pend_full",      64'(bus.pend_mask), 64'h1E);
    bus.alu_reg  = 3'd6;
    bus.alu_data = 32'hA4;
    tick();
    chk("t2_pop_en",    64'(bus.write_en),   64'(1));
    chk("t2_pop_reg",   64'(bus.write_reg),  64'(1));
    chk("t2_pop_data",  64'(bus.write_data), 64'hB0);
    chk("t2_stall_off", 64'(bus.alu_stall),  64'(0));
    chk("t2_pend_pop",  64'(bus.pend_mask),  64'h1C);
    tick();
    chk("t2_late_reg",  64'(bus.write_reg),  64'(6));
    chk("t2_late_data", 64'(bus.write_data), 64'hA4);
    idle();
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t2_drain_en",   64'(bus.write_en),   64'(1));
      chk("t2_drain_reg",  64'(bus.write_reg),  64'(i + 1));
      chk("t2_drain_data", 64'(bus.write_data), 64'(32'hB0 + 32'(i)));
    end
    tick();
    chk("t2_done_en",   64'(bus.write_en),  64'(0));
    chk("t2_done_pend", 64'(bus.pend_mask), 64'(0));

    // queued write overtaken by a later ALU write
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 3'd0;
    bus.alu_data  = 32'h55;
    bus.lu_valid  = 1'b1;
    bus.lu_reg    = 3'd3;
    bus.lu_data   = 32'h11;
    tick();
    chk("t3_alu0_data", 64'(bus.write_data), 64'h55);
    chk("t3_pend_set",  64'(bus.pend_mask),  64'h08);
    bus.lu_valid = 1'b0;
    bus.alu_reg  = 3'd3;
    bus.alu_data = 32'h22;
    tick();
    chk("t3_alu3_en",   64'(bus.write_en),   64'(1));
    chk("t3_alu3_reg",  64'(bus.write_reg),  64'(3));
    chk("t3_alu3_data", 64'(bus.write_data), 64'h22);
    chk("t3_pend_clr",  64'(bus.pend_mask),  64'(0));
    idle();
    tick();
    chk("t3_bubble_en", 64'(bus.write_en), 64'(0));
    tick();
    chk("t3_idle_en",   64'(bus.write_en), 64'(0));

    // same-cycle push and ALU write to the same register
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 3'd2;
    bus.alu_data  = 32'h33;
    bus.lu_valid  = 1'b1;
    bus.lu_reg    = 3'd2;
    bus.lu_data   = 32'h44;
    tick();
    idle();
    chk("t4_alu_en",   64'(bus.write_en),     64'(1));
    chk("t4_alu_data", 64'(bus.write_data),   64'h33);
    chk("t4_pend2",    64'(bus.pend_mask[2]), 64'(0));
    tick();
    chk("t4_bubble_en", 64'(bus.write_en), 64'(0));
    tick();
    chk("t4_idle_en",   64'(bus.write_en), 64'(0));

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_reg   = 3'(5 + i);
      bus.alu_data  = 32'hC0 + 32'(i);
      bus.lu_valid  = 1'b1;
      bus.lu_reg    = 3'(i + 1);
      bus.lu_data   = 32'hD0 + 32'(i);
      tick();
    end
    idle();
    tick();
    chk("t5_pop_reg",  64'(bus.write_reg),  64'(1));
    chk("t5_pop_data", 64'(bus.write_data), 64'hD0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_en",    64'(bus.write_en),  64'(0));
    chk("t5_rst_pend",  64'(bus.pend_mask), 64'(0));
    chk("t5_rst_ready", 64'(bus.lu_ready),  64'(1));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_post_en", 64'(bus.write_en), 64'(0));
    end

    // random back-to-back pushes against a scoreboard
    pushed = 0;
    cycles = 0;
    while ((pushed < 20 || exp_q.size() > 0) && cycles < 300) begin
      cycles++;
      if (!bus.lu_valid && pushed < 20) begin
        bus.lu_valid = 1'b1;
        bus.lu_reg   = 3'($urandom_range(1, 7));
        bus.lu_data  = $urandom;
      end
      if (!bus.alu_valid && pushed < 20 && $urandom_range(0, 3) != 0) begin
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 3'd0;
        bus.alu_data  = $urandom;
      end
      lu_acc  = bus.lu_valid && bus.lu_ready;
      alu_acc = bus.alu_valid && !bus.alu_stall;
      if (lu_acc) begin
        exp_q.push_back({bus.lu_reg, bus.lu_data});
        pushed++;
      end
      tick();
      if (alu_acc) begin
        chk("rnd_alu_write", 64'({bus.write_en, bus.write_reg, bus.write_data}),
            64'({1'b1, 3'd0, bus.alu_data}));
      end else if (bus.write_en) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_write", 64'(bus.write_en), 64'(0));
        end else begin
          exp_head = exp_q.pop_front();
          chk("rnd_lu_write", 64'({bus.write_reg, bus.write_data}), 64'(exp_head));
        end
      end
      chk("rnd_lu_ready", 64'(bus.lu_ready), 64'(exp_q.size() < 4));
      if (lu_acc)  bus.lu_valid  = 1'b0;
      if (alu_acc) bus.alu_valid = 1'b0;
    end
    idle();
    chk("rnd_pushed",  64'(pushed),       64'(20));
    chk("rnd_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter that directly drives the register file's single write port (write_reg/write_data/write_en).
- Merges two producers:
  - the single-cycle ALU result, which has priority;
  - results from the long-latency unit (load/multiply), via a valid/ready handshake and a small in-order queue.
- Squashes stale queued writes that a newer ALU write overtakes.
- Exports a pending-write mask for the hazard logic.

Parameters:
- DEPTH, 4, long-unit queue entries (power of two, 2..16).
- AW, 3, register address width (8 registers).
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_reg  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_stall  out  1  queue full; ALU result not taken this cycle, upstream holds.
- lu_valid  in  1  long-unit result offered.
- lu_reg  in  AW  long-unit destination register.
- lu_data  in  DW  long-unit result.
- lu_ready  out  1  queue can accept (= count < DEPTH).
- write_en  out  1  register-file write enable (registered).
- write_reg  out  AW  register-file write address (registered).
- write_data  out  DW  register-file write data (registered).
- pend_mask  out  2**AW  bit r set while any live queued entry targets register r.

Behaviour:
- Reset (async, rst=1):
  - count=0; rd/wr pointers=0; all entry live bits=0.
  - write_en=0, write_reg=0, write_data=0, pend_mask=0, alu_stall=0, lu_ready=1.
- Queue: circular buffer of DEPTH entries {live, reg, data}.
  - lu push when lu_valid && lu_ready.
  - lu_ready is derived from registered count only; no push into a full queue even on a same-cycle pop.
- Arbitration, each cycle, in priority order:
  - (a) count==DEPTH: head pops. If head live, output registers load head (write_en=1 next cycle), else write_en=0. alu_stall=1 and alu_valid is ignored.
  - (b) alu_valid (queue not full): output registers load alu_reg/alu_data, write_en=1 next cycle. Latency 1.
  - (c) count>0: head pops. Live head → write next cycle; dead head → bubble (write_en=0).
  - (d) otherwise write_en=0 next cycle. write_reg/write_data hold their previous values.
- alu_stall is combinational (count==DEPTH).
- Ordering guarantee from issue logic: a long-unit result is always older than any ALU result presented in the same or a later cycle.
- Squash rule: an accepted ALU write to register r clears live on every queued entry with reg==r.
  - Also applies to a same-cycle lu push with lu_reg==r: the entry is accepted but stored dead.
  - Squashed entries still occupy a slot and pop as bubbles.
- pend_mask: combinational OR over live entries. Reflects state after the previous edge.
- Pointers wrap modulo DEPTH. count is AW-independent, width clog2(DEPTH)+1.
- Same-cycle push and pop: count unchanged; pointers both advance.
- Reset mid-operation: all queued entries lost; any output write in flight is dropped (write_en forced 0).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when count==0, alu_valid==0 and an lu push occurs, the result goes straight to the output registers (write_en next cycle, latency 1). It is not enqueued, and count stays 0.
- Undefined: every lu result is enqueued. Minimum latency is 2 cycles (push edge, then pop edge).

Test Plan:
- Reset, then lu push reg=5 data=0xDEADBEEF, no ALU:
  - without WB_BYPASS_EN: write_en at cycle +2 with reg 5 / 0xDEADBEEF;
  - with it: at +1.
- Push 4 lu results (regs 1..4) while alu_valid held high to regs 6/7:
  - lu_ready=0 after 4th push;
  - alu_stall=1 the cycle count==4;
  - a head pops that cycle;
  - ALU write for that cycle is delayed one cycle and not lost.
- Queue reg=3 data=0x11, then ALU writes reg=3 data=0x22 before drain:
  - pend_mask bit3 goes 1 → 0;
  - queue pop produces a bubble;
  - the final register-file write for reg 3 is 0x22 only.
- Same-cycle lu push reg=2 and ALU write reg=2: entry stored dead, pend_mask[2]=0, only the ALU write is issued.
- Fill queue to 3 entries, assert rst mid-drain: write_en=0 immediately, pend_mask=0, lu_ready=1, no further writes after rst release.
- 20 random back-to-back pushes with wrap-around (DEPTH=4): writes emerge in push order with correct data, and count never exceeds 4.
